// File: rtl/respondedor_mdio_pkg.sv
// Shared definitions for the Clause-22 MDIO target: opcodes, frame bit positions,
// FSM state encoding and the read-only register helper.
package respondedor_mdio_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;

    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_RD = 2'b10;

    // Frame bit index counted from the first ST bit (0) to the last data bit (31)
    localparam logic [4:0] BIT_OP_END  = 5'd3;
    localparam logic [4:0] BIT_PHY_END = 5'd8;
    localparam logic [4:0] BIT_REG_END = 5'd13;
    localparam logic [4:0] BIT_TA1     = 5'd14;
    localparam logic [4:0] BIT_TA2     = 5'd15;
    localparam logic [4:0] BIT_LAST    = 5'd31;

    localparam logic [ADDR_W-1:0] REG_ID_HI = 5'd2;
    localparam logic [ADDR_W-1:0] REG_ID_LO = 5'd3;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ST2, ST_OP, ST_PHYAD, ST_REGAD, ST_TA, ST_DATA, ST_SKIP
    } mdio_state_e;

    function automatic logic is_read_only(input logic [ADDR_W-1:0] addr);
        return (addr == REG_ID_HI) || (addr == REG_ID_LO);
    endfunction

endpackage

// File: rtl/respondedor_mdio_edge_sync.sv
// Two-flop synchroniser for the master's mdc/mdio_out/mdio_oe plus mdc edge pulses.
module respondedor_mdio_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic mdc,
    input  logic mdio_out,
    input  logic mdio_oe,
    output logic mdc_rise,
    output logic mdc_fall,
    output logic mdio_s,
    output logic mdio_oe_s
);

    logic [2:0] mdc_r;
    logic [1:0] dat_r;
    logic [1:0] oe_r;

    // Synchroniser chains; mdc gets a third stage for edge detection
    always_ff @(posedge clk) begin
        if (!reset) begin
            mdc_r <= 3'b000;
            dat_r <= 2'b11;
            oe_r  <= 2'b00;
        end else begin
            mdc_r <= {mdc_r[1:0], mdc};
            dat_r <= {dat_r[0], mdio_out};
            oe_r  <= {oe_r[0], mdio_oe};
        end
    end

    assign mdc_rise  = mdc_r[1] & ~mdc_r[2];
    assign mdc_fall  = ~mdc_r[1] & mdc_r[2];
    assign mdio_s    = dat_r[1];
    assign mdio_oe_s = oe_r[1];

endmodule

// File: rtl/respondedor_mdio.sv
// Clause-22 MDIO target with a 32x16 register file; regs 2/3 hold the read-only PHY ID.
module respondedor_mdio
    import respondedor_mdio_pkg::*;
#(
    parameter logic [ADDR_W-1:0] PHY_ADDR  = 5'h01,
    parameter logic [DATA_W-1:0] PHY_ID_HI = 16'h0022,
    parameter logic [DATA_W-1:0] PHY_ID_LO = 16'h1560,
    parameter logic [DATA_W-1:0] REG_RST   = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mdc,
    input  logic              mdio_out,
    input  logic              mdio_oe,
    output logic              mdio_in,
    output logic              mdio_in_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              wr_stb,
    output logic [DATA_W-1:0] wr_data
);

    logic mdc_rise_s, mdc_fall_s, mdio_s, mdio_oe_s;

    respondedor_mdio_edge_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .mdc       (mdc),
        .mdio_out  (mdio_out),
        .mdio_oe   (mdio_oe),
        .mdc_rise  (mdc_rise_s),
        .mdc_fall  (mdc_fall_s),
        .mdio_s    (mdio_s),
        .mdio_oe_s (mdio_oe_s)
    );

    mdio_state_e       state_r;
    logic [4:0]        bit_cnt_r;
    logic [3:0]        hdr_r;
    logic [DATA_W-1:0] shift_r;
    logic              is_rd_r;
    logic              rd_done_r;
    logic [DATA_W-1:0] regs_r [32];

    logic [ADDR_W-1:0] hdr_next_s;
    logic [DATA_W-1:0] wr_word_s;

    assign hdr_next_s = {hdr_r, mdio_s};
    assign wr_word_s  = {shift_r[DATA_W-2:0], mdio_s};

    function automatic logic [DATA_W-1:0] reg_value(input logic [ADDR_W-1:0] addr);
        case (addr)
            REG_ID_HI: return PHY_ID_HI;
            REG_ID_LO: return PHY_ID_LO;
            default:   return regs_r[addr];
        endcase
    endfunction

    // Frame FSM: decode on mdc rise, drive read data on mdc fall
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 5'd0;
            hdr_r      <= 4'd0;
            shift_r    <= 16'h0000;
            is_rd_r    <= 1'b0;
            rd_done_r  <= 1'b0;
            mdio_in    <= 1'b1;
            mdio_in_oe <= 1'b0;
            reg_addr   <= 5'd0;
            wr_stb     <= 1'b0;
            wr_data    <= 16'h0000;
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= REG_RST;
            end
        end else begin
            wr_stb <= 1'b0;
            if (mdc_rise_s) begin
                hdr_r     <= hdr_next_s[3:0];
                bit_cnt_r <= bit_cnt_r + 5'd1;
                case (state_r)
                    ST_IDLE: begin
                        bit_cnt_r <= 5'd1;
                        if (!mdio_s && mdio_oe_s) begin
                            state_r <= ST_ST2;
                        end
                    end
                    ST_ST2: state_r <= mdio_s ? ST_OP : ST_IDLE;
                    ST_OP: begin
                        if (bit_cnt_r == BIT_OP_END) begin
                            is_rd_r <= (hdr_next_s[1:0] == OP_RD);
                            state_r <= (hdr_next_s[1:0] == OP_WR || hdr_next_s[1:0] == OP_RD)
                                       ? ST_PHYAD : ST_SKIP;
                        end
                    end
                    ST_PHYAD: begin
                        if (bit_cnt_r == BIT_PHY_END) begin
                            state_r <= (hdr_next_s == PHY_ADDR) ? ST_REGAD : ST_SKIP;
                        end
                    end
                    ST_REGAD: begin
                        if (bit_cnt_r == BIT_REG_END) begin
                            reg_addr <= hdr_next_s;
                            state_r  <= ST_TA;
                        end
                    end
                    ST_TA: begin
                        if (bit_cnt_r == BIT_TA1) begin
                            shift_r <= reg_value(reg_addr);
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (is_rd_r) begin
                            // Line is released on the following mdc fall
                            if (bit_cnt_r == BIT_LAST) begin
                                rd_done_r <= 1'b1;
                            end
                        end else begin
                            shift_r <= wr_word_s;
                            if (bit_cnt_r == BIT_LAST) begin
                                state_r <= ST_IDLE;
                                if (!is_read_only(reg_addr)) begin
                                    regs_r[reg_addr] <= wr_word_s;
                                    wr_stb           <= 1'b1;
                                    wr_data          <= wr_word_s;
                                end
                            end
                        end
                    end
                    ST_SKIP: begin
                        if (bit_cnt_r == BIT_LAST) begin
                            state_r <= ST_IDLE;
                        end
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end else if (mdc_fall_s && is_rd_r) begin
                case (state_r)
                    ST_TA: begin
                        if (bit_cnt_r == BIT_TA2) begin
                            mdio_in    <= 1'b0;
                            mdio_in_oe <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (rd_done_r) begin
                            mdio_in    <= 1'b1;
                            mdio_in_oe <= 1'b0;
                            rd_done_r  <= 1'b0;
                            state_r    <= ST_IDLE;
                        end else begin
                            mdio_in <= shift_r[DATA_W-1];
                            shift_r <= {shift_r[DATA_W-2:0], 1'b0};
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_respondedor_mdio.sv
// Directed bench for respondedor_mdio: a behavioural MDIO master issues frames and
// every comparison is an immediate assertion against hand-computed values.
module tb_respondedor_mdio;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        mdc;
    logic        mdio_out;
    logic        mdio_oe;
    logic        mdio_in;
    logic        mdio_in_oe;
    logic [4:0]  reg_addr;
    logic        wr_stb;
    logic [15:0] wr_data;

    int          total = 0;
    int          bad = 0;
    int          stb_cnt = 0;
    int          s0;
    logic [15:0] last_wr = 16'h0000;
    logic        oe_seen = 1'b0;
    logic [31:0] rx;

    respondedor_mdio dut (
        .clk        (clk),
        .reset      (reset),
        .mdc        (mdc),
        .mdio_out   (mdio_out),
        .mdio_oe    (mdio_oe),
        .mdio_in    (mdio_in),
        .mdio_in_oe (mdio_in_oe),
        .reg_addr   (reg_addr),
        .wr_stb     (wr_stb),
        .wr_data    (wr_data)
    );

    always #5 clk = ~clk;

    // Observe write strobes, target drive and bus conflicts away from the active edge
    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            stb_cnt++;
            last_wr = wr_data;
        end
        if (mdio_in_oe === 1'b1) oe_seen = 1'b1;
        total++;
        assert (!(mdio_oe === 1'b1 && mdio_in_oe === 1'b1)) else begin
            bad++;
            $error("FAIL bus_conflict observed mdio_oe=%b mdio_in_oe=%b expected not both 1",
                   mdio_oe, mdio_in_oe);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One 32-bit frame, MSB first; reads release the line after the 14 header bits
    task automatic send_frame(input logic [31:0] f, input logic rd, input int abort_at,
                              output logic [31:0] rxd);
        for (int i = 31; i >= 0; i--) begin
            mdio_oe  = rd ? (i >= 18) : 1'b1;
            mdio_out = (rd && i < 18) ? 1'b1 : f[i];
            tick(HALF);
            mdc    = 1'b1;
            rxd[i] = mdio_in;
            tick(HALF);
            mdc = 1'b0;
            if (i == abort_at) begin
                tick(4);
                check("t5_driving_before_reset", {31'd0, mdio_in_oe}, 32'd1);
                reset = 1'b0;
                tick(1);
                check("t5_oe_after_reset", {31'd0, mdio_in_oe}, 32'd0);
                check("t5_reg_addr_after_reset", {27'd0, reg_addr}, 32'd0);
                reset = 1'b1;
            end
        end
        mdio_oe  = 1'b0;
        mdio_out = 1'b1;
        tick(HALF);
    endtask

    task automatic read_check(input string tag, input logic [15:0] hdr, input logic [15:0] exp);
        send_frame({hdr, 16'h0000}, 1'b1, -1, rx);
        check({tag, "_ta1_undriven"}, {31'd0, rx[17]}, 32'd1);
        check({tag, "_ta2"}, {31'd0, rx[16]}, 32'd0);
        check({tag, "_data"}, {16'd0, rx[15:0]}, {16'd0, exp});
        check({tag, "_released"}, {30'd0, mdio_in_oe, mdio_in}, 32'd1);
    endtask

    initial begin
        reset    = 1'b0;
        mdc      = 1'b0;
        mdio_out = 1'b1;
        mdio_oe  = 1'b0;
        tick(3);
        check("rst_mdio_in", {31'd0, mdio_in}, 32'd1);
        check("rst_mdio_in_oe", {31'd0, mdio_in_oe}, 32'd0);
        check("rst_reg_addr", {27'd0, reg_addr}, 32'd0);
        check("rst_wr_stb", {31'd0, wr_stb}, 32'd0);
        check("rst_wr_data", {16'd0, wr_data}, 32'd0);
        reset = 1'b1;
        tick(2);

        // 1: write BEEF to reg 4
        s0 = stb_cnt; oe_seen = 1'b0;
        send_frame(32'h5092BEEF, 1'b0, -1, rx);
        check("t1_stb_count", stb_cnt - s0, 32'd1);
        check("t1_wr_data", {16'd0, last_wr}, 32'h0000BEEF);
        check("t1_reg_addr", {27'd0, reg_addr}, 32'd4);
        check("t1_no_drive", {31'd0, oe_seen}, 32'd0);

        // 2: read reg 4 back
        read_check("t2_rd_reg4", 16'h6092, 16'hBEEF);

        // 3: read-only ID registers
        read_check("t3_rd_reg2", 16'h608A, 16'h0022);
        s0 = stb_cnt;
        send_frame(32'h508EFFFF, 1'b0, -1, rx);
        check("t3_ro_write_no_stb", stb_cnt - s0, 32'd0);
        read_check("t3_rd_reg3", 16'h608E, 16'h1560);
        check("t3_reg_addr", {27'd0, reg_addr}, 32'd3);

        // 4: frame for another PHY is ignored
        s0 = stb_cnt; oe_seen = 1'b0;
        send_frame(32'h5112AAAA, 1'b0, -1, rx);
        check("t4_other_phy_no_stb", stb_cnt - s0, 32'd0);
        check("t4_other_phy_no_drive", {31'd0, oe_seen}, 32'd0);
        read_check("t4_rd_reg4", 16'h6092, 16'hBEEF);

        // 5: reset pulse during read data, then registers are back to reset value
        send_frame(32'h60920000, 1'b1, 8, rx);
        read_check("t5_rd_reg4", 16'h6092, 16'h0000);

        // 6: preamble then write to reg 5, then an OP=11 frame that must be skipped
        s0 = stb_cnt;
        send_frame(32'hFFFFFFFF, 1'b0, -1, rx);
        send_frame(32'h50961234, 1'b0, -1, rx);
        check("t6_stb_count", stb_cnt - s0, 32'd1);
        check("t6_wr_data", {16'd0, last_wr}, 32'h00001234);
        s0 = stb_cnt; oe_seen = 1'b0;
        send_frame(32'h70965555, 1'b0, -1, rx);
        check("t6_op11_no_stb", stb_cnt - s0, 32'd0);
        check("t6_op11_no_drive", {31'd0, oe_seen}, 32'd0);
        read_check("t6_rd_reg5", 16'h6096, 16'h1234);

        tick(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
